dmem_bytelane: RTL and testbench
================================

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 2048, number of 32-bit words, power of two, minimum 4.
REQ-003 SHALL have parameter INIT_ZERO, default 1; 1 = zero-fill the array after reset.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 s_mux  input  2  store size: 00 sw, 01 sh, 10 sb, 11 reserved (treated as sw).
REQ-011 l_mux  input  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101-111 reserved (treated as lw).
REQ-012 addr  input  32  byte address.
REQ-013 data_in  input  32  store data, right-justified (sb uses [7:0], sh uses [15:0]).
REQ-014 resp_valid  output  1  one-cycle response pulse.
REQ-015 data_out  output  32  load result, valid when resp_valid = 1.
REQ-016 err_misalign  output  1  alignment fault, valid when resp_valid = 1.
REQ-017 err_range  output  1  address outside the window, valid when resp_valid = 1.

Function
REQ-018 SHALL implement states INIT, IDLE and RESP; req_ready = 1 only in IDLE.
REQ-019 INIT (entered when rst_n deasserts and INIT_ZERO = 1) SHALL write zero to word index cnt each cycle, with cnt counting 0 to DEPTH_WORDS-1.
REQ-020 INIT SHALL go to IDLE on the cycle after cnt = DEPTH_WORDS-1; with INIT_ZERO = 0, reset exits directly to IDLE.
REQ-021 A request SHALL be accepted on a rising edge where state = IDLE and req_valid = 1; state then goes to RESP.
REQ-022 RESP SHALL last exactly one cycle, with resp_valid = 1 and req_ready = 0, then return to IDLE; throughput is one request per 2 cycles.
REQ-023 Word index SHALL be (addr - BASE_ADDR) >> 2, computed with 32-bit unsigned arithmetic.
REQ-024 err_range SHALL be set when addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS, with no wrap-around.
REQ-025 err_misalign SHALL be set for sw/lw with addr[1:0] != 0, and for sh/lh/lhu with addr[0] != 0; byte accesses never fault.
REQ-026 If both faults apply, both flags SHALL be 1.
REQ-027 Stores SHALL be little-endian with byte enables: sb writes lane addr[1:0]; sh writes lanes {addr[1],0} and {addr[1],1}; sw writes all four lanes.
REQ-028 Unwritten lanes SHALL keep their prior values.
REQ-029 A store SHALL commit on its accept edge only if neither fault applies.
REQ-030 For a store response, data_out SHALL be 0.
REQ-031 Loads SHALL read the word on the accept edge into a registered word, then select and extend it combinationally during RESP.
REQ-032 Load extension: lb and lh sign-extend; lbu and lhu zero-extend; lw returns the full word.
REQ-033 A faulting load SHALL return data_out = 0; a faulting access SHALL never modify memory.
REQ-034 A load accepted after a store to the same word SHALL return the post-store value, since the store committed at least 2 cycles earlier.
REQ-035 Outside RESP, resp_valid, err_misalign and err_range SHALL be 0, and data_out SHALL hold its last value.
REQ-036 req_valid in INIT or RESP SHALL be ignored (not queued); the requester must hold it until req_ready.

Reset
REQ-037 While rst_n = 0: state = INIT (or IDLE if INIT_ZERO = 0), cnt = 0, req_ready = 0, resp_valid = 0, data_out = 0, err flags = 0.
REQ-038 The memory array SHALL NOT be cleared by reset itself; only the INIT sweep clears it.
REQ-039 Reset asserted mid-INIT SHALL restart the sweep at cnt = 0.
REQ-040 Reset asserted in RESP SHALL drop resp_valid immediately; a store accepted before reset remains committed.

Verification
REQ-041 Init: release rst_n, DEPTH_WORDS = 2048 -> req_ready = 0 for exactly 2048 cycles then 1; lw 0x10010FFC -> 0x00000000.
REQ-042 Byte-lane store: sw 0x10010000 = 0x11223344; sb 0x10010001 = 0xAA; sh 0x10010002 = 0xBEEF -> lw 0x10010000 = 0xBEEFAA44.
REQ-043 Extension: word 0x10010004 = 0x80FF7F01 -> lb@+7 = 0xFFFFFF80; lbu@+7 = 0x00000080; lh@+6 = 0xFFFF80FF; lhu@+6 = 0x000080FF; lb@+4 = 0x00000001.
REQ-044 Faults: sw 0x10010002 -> err_misalign = 1 and the word is unchanged; lw 0x1000FFFC -> err_range = 1 and data_out = 0; lw 0x10012000 -> err_range = 1; sh 0x10012001 -> both flags = 1.
REQ-045 Handshake: hold req_valid high for 3 lw requests -> each resp_valid one cycle after its accept, req_ready toggles 1/0, 6 cycles total.
REQ-046 Reset mid-INIT at cnt = 100, then release -> 2048 further not-ready cycles; reset during store RESP -> resp_valid drops immediately and the stored word is retained after re-init with INIT_ZERO = 0.

Source files
------------

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: single-port word-organised data memory with byte-lane stores,
// sign/zero-extending loads, alignment and address-window fault detection.
// After reset (INIT_ZERO = 1) the array is swept to zero one word per cycle.
// A request is accepted in IDLE; the response is a one-cycle pulse in RESP.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, s_mux, l_mux     store/load select, store size, load type
//   addr, data_in            byte address, right-justified store data
//   resp_valid               one-cycle response pulse
//   data_out                 load result (0 for stores and faults), held after RESP
//   err_misalign, err_range  fault flags, qualified by resp_valid
module dmem_bytelane #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  s_mux,
    input  logic [2:0]  l_mux,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        resp_valid,
    output logic [31:0] data_out,
    output logic        err_misalign,
    output logic        err_range
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // One past the last byte of the window, kept 33 bits wide so it cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {StInit, StIdle, StResp} state_e;
    localparam state_e ResetState = INIT_ZERO ? StInit : StIdle;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    lmux_q, lmux_d;
    logic [1:0]    lane_q, lane_d;
    logic          mis_q, mis_d;
    logic          rng_q, rng_d;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic [AW-1:0] idx;
    logic          is_half, is_byte;
    logic          fault_range, fault_align;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   shifted, load_val;

    // rst_n gating keeps an INIT_ZERO = 0 block (reset state IDLE) from accepting in reset.
    assign req_ready = (state_q == StIdle) && rst_n;
    assign accept    = req_ready && req_valid;

    // Request decode: word index, access size and faults.
    always_comb begin
        idx         = AW'((addr - BASE_ADDR) >> 2);
        fault_range = ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= LIMIT);
        if (req_we) begin
            is_half = (s_mux == 2'b01);
            is_byte = (s_mux == 2'b10);
        end else begin
            is_half = (l_mux == 3'b001) || (l_mux == 3'b010);
            is_byte = (l_mux == 3'b011) || (l_mux == 3'b100);
        end
        if (is_byte) begin
            fault_align = 1'b0;
        end else if (is_half) begin
            fault_align = addr[0];
        end else begin
            fault_align = |addr[1:0];
        end

        // Store data is replicated across lanes; the byte enables pick the lanes.
        case (s_mux)
            2'b10: begin
                st_data = {4{data_in[7:0]}};
                st_be   = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_data = {2{data_in[15:0]}};
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = data_in;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Memory write port is shared between the INIT sweep and committed stores.
    always_comb begin
        if (state_q == StInit) begin
            mem_we    = rst_n;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_be    = 4'b1111;
        end else begin
            mem_we    = accept && req_we && !fault_range && !fault_align;
            mem_waddr = idx;
            mem_wdata = st_data;
            mem_be    = st_be;
        end
    end

    // Array and read register carry no reset: reset must not clear memory contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        if (accept && !req_we) begin
            rdata_q <= mem[idx];
        end
    end

    // Lane select and extension of the registered word during RESP.
    always_comb begin
        shifted = rdata_q >> {lane_q, 3'b000};
        case (lmux_q)
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {16'h0000, shifted[15:0]};
            3'b011:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'h000000, shifted[7:0]};
            default: load_val = shifted;  // lw is aligned, so lane 0 is the whole word
        endcase
        if (we_q || mis_q || rng_q) begin
            load_val = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        lmux_d  = lmux_q;
        lane_d  = lane_q;
        mis_d   = mis_q;
        rng_d   = rng_q;
        dout_d  = dout_q;
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (accept) begin
                    state_d = StResp;
                    we_d    = req_we;
                    lmux_d  = l_mux;
                    lane_d  = addr[1:0];
                    mis_d   = fault_align;
                    rng_d   = fault_range;
                end
            end
            StResp: begin
                state_d = StIdle;
                dout_d  = load_val;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ResetState;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            lmux_q  <= 3'b000;
            lane_q  <= 2'b00;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            lmux_q  <= lmux_d;
            lane_q  <= lane_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
            dout_q  <= dout_d;
        end
    end

    assign resp_valid   = (state_q == StResp);
    assign data_out     = resp_valid ? load_val : dout_q;
    assign err_misalign = resp_valid && mis_q;
    assign err_range    = resp_valid && rng_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: a byte-level memory model predicts
// every response; a per-cycle compare process checks all outputs, and directed
// sequences pin literal values. A second instance (INIT_ZERO = 0) checks
// reset during a store response.
module tb_dmem_bytelane;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_we, resp_valid, err_misalign, err_range;
    logic [1:0]  s_mux;
    logic [2:0]  l_mux;
    logic [31:0] addr, data_in, data_out;

    logic        rst2_n, req_valid2, req_ready2, req_we2, resp_valid2, err_mis2, err_rng2;
    logic [1:0]  s_mux2;
    logic [2:0]  l_mux2;
    logic [31:0] addr2, data_in2, data_out2;

    dmem_bytelane #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .s_mux(s_mux), .l_mux(l_mux), .addr(addr), .data_in(data_in),
        .resp_valid(resp_valid), .data_out(data_out), .err_misalign(err_misalign),
        .err_range(err_range)
    );

    dmem_bytelane #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .INIT_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst2_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .s_mux(s_mux2), .l_mux(l_mux2), .addr(addr2), .data_in(data_in2),
        .resp_valid(resp_valid2), .data_out(data_out2), .err_misalign(err_mis2),
        .err_range(err_rng2)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model_mem [DEPTH];
    bit          chk_en;
    bit          exp_ready, exp_valid, exp_mis, exp_rng;
    logic [31:0] exp_data;
    logic [31:0] got_data;
    logic        got_mis, got_rng;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
            chk("err_misalign", {31'b0, err_misalign}, {31'b0, exp_mis});
            chk("err_range", {31'b0, err_range}, {31'b0, exp_rng});
            chk("data_out", data_out, exp_data);
        end
    end

    // Behavioural model: byte-addressed access against the word array.
    task automatic model_access(input logic we, input logic [1:0] s, input logic [2:0] l,
                                input logic [31:0] a, input logic [31:0] d);
        int          size;
        int unsigned wi, lane;
        logic [31:0] w;
        if (we) size = (s == 2'd1) ? 2 : (s == 2'd2) ? 1 : 4;
        else    size = (l == 3'd1 || l == 3'd2) ? 2 : (l == 3'd3 || l == 3'd4) ? 1 : 4;
        exp_rng  = (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + 4 * DEPTH);
        exp_mis  = (a % size) != 0;
        exp_data = 32'h0;
        if (exp_rng || exp_mis) return;
        wi   = (a - BASE) / 4;
        lane = a % 4;
        if (we) begin
            for (int k = 0; k < size; k++) model_mem[wi][8*(lane+k) +: 8] = d[8*k +: 8];
        end else begin
            w = model_mem[wi] >> (8 * lane);
            if (size == 1) begin
                w = w & 32'hFF;
                if (l == 3'd3 && w >= 32'h80) w = w | 32'hFFFF_FF00;
            end else if (size == 2) begin
                w = w & 32'hFFFF;
                if (l == 3'd1 && w >= 32'h8000) w = w | 32'hFFFF_0000;
            end
            exp_data = w;
        end
    endtask

    // Present one request, wait for its accept edge, predict the response.
    // With hold = 1, req_valid stays high for a back-to-back follow-on request.
    task automatic issue(input logic we, input logic [1:0] s, input logic [2:0] l,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        int waitc = 0;
        req_valid = 1'b1;
        req_we    = we;
        s_mux     = s;
        l_mux     = l;
        addr      = a;
        data_in   = d;
        forever begin
            @(posedge clk);
            if (exp_ready) break;
            waitc++;
            if (waitc > 5000) begin
                chk("accept timeout", 32'h0, 32'h1);
                req_valid = 1'b0;
                return;
            end
        end
        #1;
        model_access(we, s, l, a, d);
        exp_valid = 1'b1;
        exp_ready = 1'b0;
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
        got_data = data_out;
        got_mis  = err_misalign;
        got_rng  = err_range;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_mis   = 1'b0;
        exp_rng   = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic lit(input string name, input logic [31:0] d, input logic m, input logic r);
        chk({name, " data"}, got_data, d);
        chk({name, " misalign"}, {31'b0, got_mis}, {31'b0, m});
        chk({name, " range"}, {31'b0, got_rng}, {31'b0, r});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int          c0;
        logic [31:0] a, d;
        logic        we;
        logic [1:0]  s;
        logic [2:0]  l;
        bit          hold;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; s_mux = 2'b0; l_mux = 3'b0;
        addr = 32'h0; data_in = 32'h0;
        rst2_n = 1'b0; req_valid2 = 1'b0; req_we2 = 1'b0; s_mux2 = 2'b0; l_mux2 = 3'b0;
        addr2 = 32'h0; data_in2 = 32'h0;
        exp_ready = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0; exp_rng = 1'b0; exp_data = 32'h0;
        got_data = 32'h0; got_mis = 1'b0; got_rng = 1'b0;
        chk_en = 1'b1;

        // Reset values, then a sweep interrupted at cnt = 100 and restarted.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1 exp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        // Array swept to zero.
        issue(1'b0, 2'd0, 3'd0, 32'h1001_0FFC, 32'h0, 1'b0);
        lit("lw after init", 32'h0, 1'b0, 1'b0);
        issue(1'b0, 2'd0, 3'd0, 32'h1001_1FFC, 32'h0, 1'b0);
        lit("lw last word", 32'h0, 1'b0, 1'b0);

        // Byte-lane stores.
        issue(1'b1, 2'd0, 3'd0, 32'h1001_0000, 32'h1122_3344, 1'b0);
        lit("sw resp", 32'h0, 1'b0, 1'b0);
        issue(1'b1, 2'd2, 3'd0, 32'h1001_0001, 32'h0000_00AA, 1'b0);
        issue(1'b1, 2'd1, 3'd0, 32'h1001_0002, 32'h0000_BEEF, 1'b0);
        issue(1'b0, 2'd0, 3'd0, 32'h1001_0000, 32'h0, 1'b0);
        lit("lw merged lanes", 32'hBEEF_AA44, 1'b0, 1'b0);

        // Load extension.
        issue(1'b1, 2'd0, 3'd0, 32'h1001_0004, 32'h80FF_7F01, 1'b0);
        issue(1'b0, 2'd0, 3'd3, 32'h1001_0007, 32'h0, 1'b0);
        lit("lb +7", 32'hFFFF_FF80, 1'b0, 1'b0);
        issue(1'b0, 2'd0, 3'd4, 32'h1001_0007, 32'h0, 1'b0);
        lit("lbu +7", 32'h0000_0080, 1'b0, 1'b0);
        issue(1'b0, 2'd0, 3'd1, 32'h1001_0006, 32'h0, 1'b0);
        lit("lh +6", 32'hFFFF_80FF, 1'b0, 1'b0);
        issue(1'b0, 2'd0, 3'd2, 32'h1001_0006, 32'h0, 1'b0);
        lit("lhu +6", 32'h0000_80FF, 1'b0, 1'b0);
        issue(1'b0, 2'd0, 3'd3, 32'h1001_0004, 32'h0, 1'b0);
        lit("lb +4", 32'h0000_0001, 1'b0, 1'b0);

        // Faults.
        issue(1'b1, 2'd0, 3'd0, 32'h1001_0002, 32'hDEAD_BEEF, 1'b0);
        lit("sw misaligned", 32'h0, 1'b1, 1'b0);
        issue(1'b0, 2'd0, 3'd0, 32'h1001_0000, 32'h0, 1'b0);
        lit("word after faulting sw", 32'hBEEF_AA44, 1'b0, 1'b0);
        issue(1'b0, 2'd0, 3'd0, 32'h1000_FFFC, 32'h0, 1'b0);
        lit("lw below window", 32'h0, 1'b0, 1'b1);
        issue(1'b0, 2'd0, 3'd0, 32'h1001_2000, 32'h0, 1'b0);
        lit("lw above window", 32'h0, 1'b0, 1'b1);
        issue(1'b1, 2'd1, 3'd0, 32'h1001_2001, 32'h1234, 1'b0);
        lit("sh both faults", 32'h0, 1'b1, 1'b1);

        // Back-to-back: three loads with req_valid held take six cycles.
        c0 = cyc;
        issue(1'b0, 2'd0, 3'd0, 32'h1001_0000, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 3'd0, 32'h1001_0004, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 3'd0, 32'h1001_0008, 32'h0, 1'b0);
        chk("burst cycles", 32'(cyc - c0), 32'd6);

        // Randomized traffic around the window edges and a small hot region.
        for (int it = 0; it < 500; it++) begin
            we = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            l  = 3'($urandom_range(0, 7));
            d  = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: a = BASE + 32'($urandom_range(0, 63));
                5:             a = BASE + 32'h2000 - 32'd16 + 32'($urandom_range(0, 31));
                6:             a = BASE - 32'd16 + 32'($urandom_range(0, 31));
                default:       a = $urandom;
            endcase
            hold = 1'($urandom_range(0, 1));
            issue(we, s, l, a, d, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);

        // Reset during a store response on the INIT_ZERO = 0 instance.
        rst2_n = 1'b1;
        #1 chk("nz ready after reset", {31'b0, req_ready2}, 32'h1);
        req_valid2 = 1'b1; req_we2 = 1'b1; s_mux2 = 2'd0; addr2 = BASE + 32'd8;
        data_in2 = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        chk("nz resp_valid in RESP", {31'b0, resp_valid2}, 32'h1);
        rst2_n = 1'b0;
        #1;
        chk("nz resp_valid on reset", {31'b0, resp_valid2}, 32'h0);
        chk("nz ready in reset", {31'b0, req_ready2}, 32'h0);
        chk("nz data_out in reset", data_out2, 32'h0);
        @(negedge clk);
        rst2_n = 1'b1;
        req_valid2 = 1'b1; req_we2 = 1'b0; l_mux2 = 3'd0; addr2 = BASE + 32'd8;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(negedge clk);
        chk("nz resp_valid load", {31'b0, resp_valid2}, 32'h1);
        chk("nz retained word", data_out2, 32'hCAFE_F00D);
        chk("nz load flags", {30'b0, err_mis2, err_rng2}, 32'h0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
